// File: rtl/mbs_fetch_stage_pkg.sv
// Shared constants for the MBS instruction-fetch stage:
// fetch FSM encodings, the NOP word and the default datapath width.
package mbs_fetch_stage_pkg;

    localparam int MBS_DATA_WIDTH = 32;

    localparam logic [1:0] IF_IDLE = 2'd0;
    localparam logic [1:0] IF_REQ  = 2'd1;
    localparam logic [1:0] IF_WAIT = 2'd2;
    localparam logic [1:0] IF_DROP = 2'd3;

    localparam logic [31:0] MBS_NOP_INST = 32'h0000_0000;

endpackage

// File: rtl/mbs_fetch_skid.sv
// One-entry {inst, pc} skid buffer between the fetch FSM and IF/ID.
// Clear wins over load, load wins over drain.
module mbs_fetch_skid
    import mbs_fetch_stage_pkg::*;
#(
    parameter int W = MBS_DATA_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_drain,
    input  logic         i_clear,
    input  logic [W-1:0] i_inst,
    input  logic [W-1:0] i_pc,
    output logic         o_full,
    output logic [W-1:0] o_inst,
    output logic [W-1:0] o_pc
);

    logic         r_full;
    logic [W-1:0] r_inst;
    logic [W-1:0] r_pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_full <= 1'b0;
            r_inst <= '0;
            r_pc   <= '0;
        end else if (i_clear) begin
            r_full <= 1'b0;
        end else if (i_load) begin
            r_full <= 1'b1;
            r_inst <= i_inst;
            r_pc   <= i_pc;
        end else if (i_drain) begin
            r_full <= 1'b0;
        end
    end

    assign o_full = r_full;
    assign o_inst = r_inst;
    assign o_pc   = r_pc;

endmodule

// File: rtl/mbs_fetch_stage.sv
// MBS IF stage: PC, one-outstanding imem port, IF/ID register and skid.
// MBS_FETCH_ALIGN_CHECK_EN adds if_id_fault for misaligned redirects.
module mbs_fetch_stage
    import mbs_fetch_stage_pkg::*;
#(
    parameter int                    DATA_WIDTH = MBS_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_gnt,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    input  logic                  id_stall,
`ifdef MBS_FETCH_ALIGN_CHECK_EN
    output logic                  if_id_fault,
`endif
    output logic                  if_id_valid,
    output logic [DATA_WIDTH-1:0] if_id_inst,
    output logic [DATA_WIDTH-1:0] if_id_pc,
    output logic [DATA_WIDTH-1:0] if_id_pc_plus4
);

    logic [1:0]            r_state;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_req_pc;
    logic                  r_if_valid;
    logic [DATA_WIDTH-1:0] r_if_inst;
    logic [DATA_WIDTH-1:0] r_if_pc;
    logic [DATA_WIDTH-1:0] r_if_pc4;

    logic                  w_skid_full;
    logic [DATA_WIDTH-1:0] w_skid_inst;
    logic [DATA_WIDTH-1:0] w_skid_pc;
    logic                  w_deliver;
    logic                  w_drain;
    logic                  w_skid_load;
    logic                  w_if_load;
    logic                  w_busy;
    logic                  w_misalign;
    logic                  w_halt;
    logic [DATA_WIDTH-1:0] w_rpc;

`ifdef MBS_FETCH_ALIGN_CHECK_EN
    logic r_halt;
    logic r_fault;

    assign w_misalign = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign w_rpc      = redirect_pc;
    assign w_halt     = r_halt;

    // A misaligned target parks fetch until the next redirect.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_halt  <= 1'b0;
            r_fault <= 1'b0;
        end else if (redirect_valid) begin
            r_halt  <= w_misalign;
            r_fault <= w_misalign;
        end else if (w_drain || w_if_load || !id_stall) begin
            r_fault <= 1'b0;
        end
    end

    assign if_id_fault = r_fault;
`else
    assign w_misalign = 1'b0;
    assign w_rpc      = redirect_pc & ~DATA_WIDTH'(3);
    assign w_halt     = 1'b0;
`endif

    always_comb begin
        w_deliver   = (r_state == IF_WAIT) && imem_rvalid && !redirect_valid;
        w_drain     = w_skid_full && !id_stall && !redirect_valid;
        w_skid_load = w_deliver && (w_drain || (r_if_valid && id_stall));
        w_if_load   = w_deliver && !w_skid_load;
        // A granted request whose response is still to come.
        w_busy      = ((r_state == IF_REQ) && imem_gnt)
                   || (((r_state == IF_WAIT) || (r_state == IF_DROP))
                       && !imem_rvalid);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IF_IDLE;
            r_pc     <= RESET_PC;
            r_req_pc <= '0;
        end else if (redirect_valid) begin
            r_pc <= w_rpc;
            if (w_busy)
                r_state <= IF_DROP;
            else if (w_misalign)
                r_state <= IF_IDLE;
            else
                r_state <= IF_REQ;
        end else begin
            case (r_state)
                IF_IDLE: begin
                    if (!w_halt && (!w_skid_full || w_drain))
                        r_state <= IF_REQ;
                end
                IF_REQ: begin
                    if (imem_gnt) begin
                        r_req_pc <= r_pc;
                        r_pc     <= r_pc + DATA_WIDTH'(4);
                        r_state  <= IF_WAIT;
                    end
                end
                IF_WAIT: begin
                    if (imem_rvalid)
                        r_state <= w_skid_load ? IF_IDLE : IF_REQ;
                end
                default: begin
                    if (imem_rvalid)
                        r_state <= w_halt ? IF_IDLE : IF_REQ;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_if_valid <= 1'b0;
            r_if_inst  <= '0;
            r_if_pc    <= '0;
            r_if_pc4   <= '0;
        end else if (redirect_valid) begin
            r_if_valid <= w_misalign;
            if (w_misalign) begin
                r_if_inst <= DATA_WIDTH'(MBS_NOP_INST);
                r_if_pc   <= redirect_pc;
                r_if_pc4  <= redirect_pc + DATA_WIDTH'(4);
            end
        end else if (w_drain) begin
            r_if_valid <= 1'b1;
            r_if_inst  <= w_skid_inst;
            r_if_pc    <= w_skid_pc;
            r_if_pc4   <= w_skid_pc + DATA_WIDTH'(4);
        end else if (w_if_load) begin
            r_if_valid <= 1'b1;
            r_if_inst  <= imem_rdata;
            r_if_pc    <= r_req_pc;
            r_if_pc4   <= r_req_pc + DATA_WIDTH'(4);
        end else if (!id_stall) begin
            r_if_valid <= 1'b0;
        end
    end

    mbs_fetch_skid #(
        .W (DATA_WIDTH)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_skid_load),
        .i_drain (w_drain),
        .i_clear (redirect_valid),
        .i_inst  (imem_rdata),
        .i_pc    (r_req_pc),
        .o_full  (w_skid_full),
        .o_inst  (w_skid_inst),
        .o_pc    (w_skid_pc)
    );

    assign imem_req       = (r_state == IF_REQ);
    assign imem_addr      = r_pc;
    assign if_id_valid    = r_if_valid;
    assign if_id_inst     = r_if_inst;
    assign if_id_pc       = r_if_pc;
    assign if_id_pc_plus4 = r_if_pc4;

endmodule

// File: tb/tb_mbs_fetch_stage.sv
// Directed bench for mbs_fetch_stage with a latency-configurable imem.
// Memory word for address a is 32'h2408_0001 + a.
module tb_mbs_fetch_stage;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_stall;
    logic        if_id_valid;
    logic [31:0] if_id_inst;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
`ifdef MBS_FETCH_ALIGN_CHECK_EN
    logic        if_id_fault;
`endif

    int          total;
    int          bad;
    int          lat;
    logic        gnt_en;
    logic        pend;
    int          cnt;
    logic [31:0] paddr;

    mbs_fetch_stage #(
        .DATA_WIDTH (32),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_stall       (id_stall),
`ifdef MBS_FETCH_ALIGN_CHECK_EN
        .if_id_fault    (if_id_fault),
`endif
        .if_id_valid    (if_id_valid),
        .if_id_inst     (if_id_inst),
        .if_id_pc       (if_id_pc),
        .if_id_pc_plus4 (if_id_pc_plus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_gnt    = imem_req & gnt_en;
    assign imem_rvalid = pend && (cnt == 0);
    assign imem_rdata  = imem_rvalid ? (32'h2408_0001 + paddr) : 32'hDEAD_BEEF;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend  <= 1'b0;
            cnt   <= 0;
            paddr <= '0;
        end else if (imem_req && imem_gnt) begin
            pend  <= 1'b1;
            cnt   <= lat - 1;
            paddr <= imem_addr;
        end else if (pend) begin
            if (cnt != 0)
                cnt <= cnt - 1;
            else
                pend <= 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        lat            = 1;
        gnt_en         = 1'b1;
        rst            = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        id_stall       = 1'b0;

        #12;
        chk("rst_valid", 32'(if_id_valid), 32'd0);
        chk("rst_inst", if_id_inst, 32'h0);
        chk("rst_pc", if_id_pc, 32'h0);
        chk("rst_pc4", if_id_pc_plus4, 32'h0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        rst = 1'b1;

        // Segment A: 1-cycle memory, first fetch and decode stall.
        tick();
        chk("a1_req", 32'(imem_req), 32'd1);
        chk("a1_addr", imem_addr, 32'h0);
        tick();
        chk("a2_req", 32'(imem_req), 32'd0);
        tick();
        chk("a3_valid", 32'(if_id_valid), 32'd1);
        chk("a3_pc", if_id_pc, 32'h0);
        chk("a3_pc4", if_id_pc_plus4, 32'h4);
        chk("a3_inst", if_id_inst, 32'h2408_0001);
        chk("a3_addr", imem_addr, 32'h4);
        id_stall = 1'b1;
        tick();
        tick();
        chk("a5_pc", if_id_pc, 32'h0);
        chk("a5_valid", 32'(if_id_valid), 32'd1);
        chk("a5_req", 32'(imem_req), 32'd0);
        tick();
        chk("a6_req", 32'(imem_req), 32'd0);
        chk("a6_pc", if_id_pc, 32'h0);
        tick();
        chk("a7_req", 32'(imem_req), 32'd0);
        id_stall = 1'b0;
        tick();
        chk("a8_valid", 32'(if_id_valid), 32'd1);
        chk("a8_pc", if_id_pc, 32'h4);
        chk("a8_inst", if_id_inst, 32'h2408_0005);
        chk("a8_pc4", if_id_pc_plus4, 32'h8);
        chk("a8_addr", imem_addr, 32'h8);
        chk("a8_req", 32'(imem_req), 32'd1);
        tick();
        chk("a9_valid", 32'(if_id_valid), 32'd0);
        tick();
        chk("a10_valid", 32'(if_id_valid), 32'd1);
        chk("a10_pc", if_id_pc, 32'h8);
        chk("a10_inst", if_id_inst, 32'h2408_0009);

        // Segment B: 2-cycle memory, redirects in WAIT and on grant.
        rst = 1'b0;
        lat = 2;
        #2;
        chk("b_rst_valid", 32'(if_id_valid), 32'd0);
        rst = 1'b1;
        repeat (8) tick();
        chk("b8_req", 32'(imem_req), 32'd0);
        chk("b8_pc", if_id_pc, 32'h4);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        tick();
        redirect_valid = 1'b0;
        chk("b9_valid", 32'(if_id_valid), 32'd0);
        chk("b9_req", 32'(imem_req), 32'd0);
        tick();
        chk("b10_valid", 32'(if_id_valid), 32'd0);
        chk("b10_req", 32'(imem_req), 32'd1);
        chk("b10_addr", imem_addr, 32'h100);
        tick();
        chk("b11_valid", 32'(if_id_valid), 32'd0);
        tick();
        chk("b12_valid", 32'(if_id_valid), 32'd0);
        tick();
        chk("b13_valid", 32'(if_id_valid), 32'd1);
        chk("b13_pc", if_id_pc, 32'h100);
        chk("b13_inst", if_id_inst, 32'h2408_0101);
        chk("b13_addr", imem_addr, 32'h104);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        tick();
        redirect_valid = 1'b0;
        chk("b14_req", 32'(imem_req), 32'd0);
        chk("b14_valid", 32'(if_id_valid), 32'd0);
        tick();
        chk("b15_req", 32'(imem_req), 32'd0);
        tick();
        chk("b16_req", 32'(imem_req), 32'd1);
        chk("b16_addr", imem_addr, 32'h200);
        chk("b16_valid", 32'(if_id_valid), 32'd0);
        tick();
        tick();
        chk("b18_valid", 32'(if_id_valid), 32'd0);
        tick();
        chk("b19_valid", 32'(if_id_valid), 32'd1);
        chk("b19_pc", if_id_pc, 32'h200);
        chk("b19_inst", if_id_inst, 32'h2408_0201);

        // Wrap at the top of the address space; redirect beats id_stall.
        gnt_en         = 1'b0;
        lat            = 1;
        id_stall       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        id_stall       = 1'b0;
        gnt_en         = 1'b1;
        chk("w20_valid", 32'(if_id_valid), 32'd0);
        chk("w20_addr", imem_addr, 32'hFFFF_FFFC);
        chk("w20_req", 32'(imem_req), 32'd1);
        tick();
        tick();
        chk("w22_valid", 32'(if_id_valid), 32'd1);
        chk("w22_pc", if_id_pc, 32'hFFFF_FFFC);
        chk("w22_pc4", if_id_pc_plus4, 32'h0);
        chk("w22_inst", if_id_inst, 32'h2407_FFFD);
        chk("w22_addr", imem_addr, 32'h0);
        chk("w22_req", 32'(imem_req), 32'd1);

        // Misaligned redirect target.
        gnt_en         = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0302;
        tick();
        redirect_valid = 1'b0;
        gnt_en         = 1'b1;
`ifdef MBS_FETCH_ALIGN_CHECK_EN
        chk("m_fault", 32'(if_id_fault), 32'd1);
        chk("m_valid", 32'(if_id_valid), 32'd1);
        chk("m_inst", if_id_inst, 32'h0);
        chk("m_pc", if_id_pc, 32'h302);
        chk("m_pc4", if_id_pc_plus4, 32'h306);
        chk("m_req", 32'(imem_req), 32'd0);
        tick();
        chk("m1_req", 32'(imem_req), 32'd0);
        tick();
        chk("m2_req", 32'(imem_req), 32'd0);
        tick();
        chk("m3_req", 32'(imem_req), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        tick();
        redirect_valid = 1'b0;
        chk("m4_req", 32'(imem_req), 32'd1);
        chk("m4_addr", imem_addr, 32'h200);
        chk("m4_fault", 32'(if_id_fault), 32'd0);
        tick();
        tick();
        chk("m6_valid", 32'(if_id_valid), 32'd1);
        chk("m6_pc", if_id_pc, 32'h200);
        chk("m6_fault", 32'(if_id_fault), 32'd0);
`else
        chk("m_addr", imem_addr, 32'h300);
        chk("m_req", 32'(imem_req), 32'd1);
        chk("m_valid", 32'(if_id_valid), 32'd0);
        tick();
        tick();
        chk("m2_valid", 32'(if_id_valid), 32'd1);
        chk("m2_pc", if_id_pc, 32'h300);
        chk("m2_inst", if_id_inst, 32'h2408_0301);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
